// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states and grant owners.
package sdram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CPU_ISSUE = 3'd1,
      CPU_WAIT  = 3'd2,
      VID_ISSUE = 3'd3,
      VID_DRAIN = 3'd4
   } arb_state_t;

   // Owner of the most recent grant; used to alternate under contention
   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_VID = 1'b1
   } grant_t;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Shares one single-command SDRAM controller port between the CPU (single
// word reads/writes) and the video fetcher (fixed-length pipelined read
// bursts). Grants alternate when both sides are pending.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int C_ADDR_BITS = 22,
   parameter int C_DATA_BITS = 32,
   parameter int C_BURST_LEN = 16,
   parameter int C_MAX_OUTST = 4
) (
   input  logic                     clk_sdram,
   input  logic                     sys_reset,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [C_ADDR_BITS-1:0]   cpu_addr,
   input  logic [C_DATA_BITS-1:0]   cpu_wdata,
   input  logic [C_DATA_BITS/8-1:0] cpu_be,
   output logic                     cpu_ack,
   output logic [C_DATA_BITS-1:0]   cpu_rdata,
   input  logic                     vid_req,
   input  logic [C_ADDR_BITS-1:0]   vid_addr,
   output logic                     vid_start,
   output logic                     vid_rvalid,
   output logic [C_DATA_BITS-1:0]   vid_rdata,
   output logic                     vid_done,
   output logic                     ctrl_req,
   output logic                     ctrl_we,
   output logic [C_ADDR_BITS-1:0]   ctrl_addr,
   output logic [C_DATA_BITS-1:0]   ctrl_wdata,
   output logic [C_DATA_BITS/8-1:0] ctrl_be,
   input  logic                     ctrl_accept,
   input  logic                     ctrl_rvalid,
   input  logic [C_DATA_BITS-1:0]   ctrl_rdata
);

   localparam int CW = $clog2(C_BURST_LEN) + 1;
   localparam logic [CW-1:0] LEN  = CW'(C_BURST_LEN);
   localparam logic [CW-1:0] MAXO = CW'(C_MAX_OUTST);

   arb_state_t             state;
   grant_t                 last_grant;
   logic [CW-1:0]          issued;
   logic [CW-1:0]          returned;
   logic [C_ADDR_BITS-1:0] base;

   logic          cpu_pend;
   logic          pick_vid;
   logic [CW-1:0] issued_nx;
   logic [CW-1:0] returned_nx;
   logic          vid_elig;

   // Arbitration and next-cycle burst bookkeeping. A CPU request still high
   // in the ack cycle is the one being retired, so it is not re-granted.
   always_comb begin
      cpu_pend    = cpu_req & ~cpu_ack;
      pick_vid    = vid_req & (~cpu_pend | (last_grant == GNT_CPU));
      issued_nx   = issued + CW'(ctrl_req & ctrl_accept);
      returned_nx = returned + CW'(ctrl_rvalid);
      vid_elig    = (issued_nx < LEN) && ((issued_nx - returned_nx) < MAXO);
   end

   // Main FSM; every output is registered here.
   always_ff @(posedge clk_sdram or negedge sys_reset) begin
      if (!sys_reset) begin
         state      <= IDLE;
         last_grant <= GNT_CPU;
         issued     <= '0;
         returned   <= '0;
         base       <= '0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         vid_start  <= 1'b0;
         vid_rvalid <= 1'b0;
         vid_rdata  <= '0;
         vid_done   <= 1'b0;
         ctrl_req   <= 1'b0;
         ctrl_we    <= 1'b0;
         ctrl_addr  <= '0;
         ctrl_wdata <= '0;
         ctrl_be    <= '0;
      end else begin
         cpu_ack    <= 1'b0;
         vid_start  <= 1'b0;
         vid_rvalid <= 1'b0;
         vid_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vid) begin
                  state      <= VID_ISSUE;
                  last_grant <= GNT_VID;
                  vid_start  <= 1'b1;
                  base       <= vid_addr;
                  issued     <= '0;
                  returned   <= '0;
                  ctrl_req   <= 1'b1;
                  ctrl_we    <= 1'b0;
                  ctrl_addr  <= vid_addr;
                  ctrl_be    <= '1;
               end else if (cpu_pend) begin
                  state      <= CPU_ISSUE;
                  last_grant <= GNT_CPU;
                  ctrl_req   <= 1'b1;
                  ctrl_we    <= cpu_we;
                  ctrl_addr  <= cpu_addr;
                  ctrl_wdata <= cpu_wdata;
                  ctrl_be    <= cpu_we ? cpu_be : '1;
               end
            end
            CPU_ISSUE: begin
               if (ctrl_accept) begin
                  ctrl_req <= 1'b0;
                  state    <= CPU_WAIT;
               end
            end
            CPU_WAIT: begin
               if (ctrl_rvalid) begin
                  cpu_ack <= 1'b1;
                  if (!ctrl_we) cpu_rdata <= ctrl_rdata;
                  state   <= IDLE;
               end
            end
            VID_ISSUE, VID_DRAIN: begin
               issued    <= issued_nx;
               returned  <= returned_nx;
               ctrl_req  <= vid_elig;
               // Address wraps silently at the top of the word space
               ctrl_addr <= base + C_ADDR_BITS'(issued_nx);
               if (ctrl_rvalid) begin
                  vid_rvalid <= 1'b1;
                  vid_rdata  <= ctrl_rdata;
               end
               if (returned_nx == LEN) begin
                  vid_done <= 1'b1;
                  ctrl_req <= 1'b0;
                  state    <= IDLE;
               end else if (issued_nx == LEN) begin
                  state <= VID_DRAIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a behavioural controller model with
// configurable latency/backpressure, plus scoreboards for CPU and video data.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

   localparam int A  = 22;
   localparam int D  = 32;
   localparam int BL = 16;
   localparam int MO = 4;

   logic          clk_sdram = 1'b0;
   logic          sys_reset = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [A-1:0]  cpu_addr = '0;
   logic [D-1:0]  cpu_wdata = '0;
   logic [3:0]    cpu_be = '0;
   logic          cpu_ack;
   logic [D-1:0]  cpu_rdata;
   logic          vid_req = 1'b0;
   logic [A-1:0]  vid_addr = '0;
   logic          vid_start, vid_rvalid, vid_done;
   logic [D-1:0]  vid_rdata;
   logic          ctrl_req, ctrl_we;
   logic [A-1:0]  ctrl_addr;
   logic [D-1:0]  ctrl_wdata;
   logic [3:0]    ctrl_be;
   logic          ctrl_accept = 1'b0, ctrl_rvalid = 1'b0;
   logic [D-1:0]  ctrl_rdata = '0;

   sdram_port_arbiter #(.C_ADDR_BITS(A), .C_DATA_BITS(D), .C_BURST_LEN(BL), .C_MAX_OUTST(MO)) dut (
      .clk_sdram(clk_sdram), .sys_reset(sys_reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_start(vid_start),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_done(vid_done),
      .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
      .ctrl_be(ctrl_be), .ctrl_accept(ctrl_accept), .ctrl_rvalid(ctrl_rvalid), .ctrl_rdata(ctrl_rdata)
   );

   always #5 clk_sdram = ~clk_sdram;

   int cyc = 0;
   always @(posedge clk_sdram) cyc <= cyc + 1;

   typedef struct {
      logic [A-1:0] addr;
      logic         we;
      logic [3:0]   be;
      logic [D-1:0] wdata;
      int           due;
   } cmd_t;

   typedef struct {
      bit           is_rd;
      logic [D-1:0] data;
   } cexp_t;

   cmd_t         pend[$];
   cmd_t         acc_log[$];
   cexp_t        cpu_exp[$];
   logic [D-1:0] vid_exp[$];
   byte          order[$];
   bit           rv_at[256];

   int  n_chk = 0, n_fail = 0;
   int  lat = 3;
   bit  accept_en = 1'b1, hold_rv = 1'b0;
   int  n_done = 0, n_vstart = 0, vid_cnt = 0;

   function automatic logic [D-1:0] mem_rd(input logic [A-1:0] a);
      return (a == 22'h000123) ? 32'hDEADBEEF : {10'h2A5, a};
   endfunction

   task automatic tick();
      @(posedge clk_sdram);
      #1;
   endtask

   // Controller model: accepts when enabled, returns in order after lat cycles
   initial begin : ctrl_model
      cmd_t c;
      forever begin
         tick();
         ctrl_accept = 1'b0;
         ctrl_rvalid = 1'b0;
         if (!sys_reset) begin
            pend.delete();
            rv_at[cyc & 255] = 1'b0;
         end else begin
            if (pend.size() > 0 && !hold_rv && pend[0].due <= cyc) begin
               ctrl_rvalid = 1'b1;
               ctrl_rdata  = pend[0].we ? 32'h0 : mem_rd(pend[0].addr);
               void'(pend.pop_front());
            end
            rv_at[cyc & 255] = ctrl_rvalid;
            if (ctrl_req && accept_en) begin
               ctrl_accept = 1'b1;
               c.addr = ctrl_addr; c.we = ctrl_we; c.be = ctrl_be;
               c.wdata = ctrl_wdata; c.due = cyc + lat;
               pend.push_back(c);
               acc_log.push_back(c);
            end
         end
      end
   end

   // Output monitor: pops scoreboards on cpu_ack / vid_rvalid
   initial begin : monitor
      cexp_t e;
      logic [D-1:0] v;
      forever begin
         tick();
         if (sys_reset) begin
            if (vid_start) n_vstart++;
            if (cpu_ack) begin
               order.push_back("C");
               n_chk++;
               if (rv_at[(cyc - 1) & 255] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL cpu_ack_latency: ack at cycle %0d without ctrl_rvalid in the cycle before", cyc);
               end
               n_chk++;
               if (cpu_exp.size() == 0) begin
                  n_fail++;
                  $display("FAIL cpu_ack_unexpected: got ack, required none");
               end else begin
                  e = cpu_exp.pop_front();
                  if (e.is_rd) begin
                     n_chk++;
                     if (cpu_rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, e.data);
                     end
                  end
               end
            end
            if (vid_rvalid) begin
               vid_cnt++;
               n_chk++;
               if (rv_at[(cyc - 1) & 255] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL vid_rvalid_latency: rvalid at cycle %0d without ctrl_rvalid before", cyc);
               end
               n_chk++;
               if (vid_exp.size() == 0) begin
                  n_fail++;
                  $display("FAIL vid_rvalid_unexpected: got word %h, required none", vid_rdata);
               end else begin
                  v = vid_exp.pop_front();
                  if (vid_rdata !== v) begin
                     n_fail++;
                     $display("FAIL vid_rdata: got %h required %h", vid_rdata, v);
                  end
               end
               n_chk++;
               if (vid_done !== ((vid_cnt % BL) == 0)) begin
                  n_fail++;
                  $display("FAIL vid_done_position: got %b at word %0d, required %b", vid_done, vid_cnt, (vid_cnt % BL) == 0);
               end
               if (vid_done) begin
                  n_done++;
                  order.push_back("V");
               end
            end else if (vid_done) begin
               n_chk++;
               n_fail++;
               $display("FAIL vid_done_alone: got vid_done=1 without vid_rvalid, required 0");
            end
         end
      end
   end

   task automatic cpu_txn(input logic we, input logic [A-1:0] a, input logic [D-1:0] wd,
                          input logic [3:0] be, input logic [D-1:0] exp_rd);
      cexp_t e;
      int n;
      e.is_rd = !we;
      e.data  = exp_rd;
      cpu_exp.push_back(e);
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be; cpu_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!cpu_ack && n < 300);
      n_chk++;
      if (!cpu_ack) begin
         n_fail++;
         $display("FAIL cpu_ack_timeout: got no ack, required ack within 300 cycles");
         cpu_exp.delete();
      end
      cpu_req = 1'b0;
   endtask

   task automatic vid_txn(input logic [A-1:0] b);
      int n;
      for (int i = 0; i < BL; i++) vid_exp.push_back(mem_rd(b + A'(i)));
      vid_addr = b; vid_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!vid_start && n < 300);
      n_chk++;
      if (!vid_start) begin
         n_fail++;
         $display("FAIL vid_start_timeout: got no vid_start, required one within 300 cycles");
      end
      vid_req = 1'b0;
   endtask

   task automatic wait_vdone(input int target);
      for (int i = 0; i < 500 && n_done < target; i++) tick();
      n_chk++;
      if (n_done < target) begin
         n_fail++;
         $display("FAIL vid_done_timeout: got %0d bursts done, required %0d", n_done, target);
      end
   endtask

   task automatic test_reset();
      int n;
      repeat (3) tick();
      n_chk++;
      if ({cpu_ack, cpu_rdata, vid_start, vid_rvalid, vid_rdata, vid_done, ctrl_req,
           ctrl_we, ctrl_addr, ctrl_wdata, ctrl_be} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got nonzero outputs, required all 0");
      end
      sys_reset = 1'b1;
      tick();
      // Start a burst that the controller never accepts, then reset mid-issue
      accept_en = 1'b0;
      vid_addr = 22'h000040; vid_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!vid_start && n < 50);
      vid_req = 1'b0;
      tick(); tick();
      n_chk++;
      if (ctrl_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_burst_req: got ctrl_req=%b, required 1", ctrl_req);
      end
      #2;
      sys_reset = 1'b0;
      #1;
      n_chk++;
      if ({cpu_ack, cpu_rdata, vid_start, vid_rvalid, vid_rdata, vid_done, ctrl_req,
           ctrl_we, ctrl_addr, ctrl_wdata, ctrl_be} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_burst: got nonzero outputs, required all 0");
      end
      vid_exp.delete();
      acc_log.delete();
      tick(); tick();
      sys_reset = 1'b1;
      accept_en = 1'b1;
      lat = 5;
      tick();
      cpu_txn(1'b0, 22'h000123, '0, 4'hF, 32'hDEADBEEF);
   endtask

   task automatic test_cpu_read();
      acc_log.delete();
      lat = 5;
      tick();
      cpu_txn(1'b0, 22'h000123, '0, 4'h0, 32'hDEADBEEF);
      n_chk++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL cpu_read_data: got %h required DEADBEEF", cpu_rdata);
      end
      n_chk++;
      if (acc_log.size() != 1 || acc_log[0].addr !== 22'h000123 || acc_log[0].we !== 1'b0
          || acc_log[0].be !== 4'hF) begin
         n_fail++;
         $display("FAIL cpu_read_cmd: got %0d commands, required 1 read to 000123 with be=F",
                  acc_log.size());
      end
      tick();
   endtask

   task automatic test_video_burst();
      logic [A-1:0] ea;
      acc_log.delete();
      lat = 3;
      vid_txn(22'h3FFFF8);
      wait_vdone(n_done + 1);
      n_chk++;
      if (acc_log.size() != BL) begin
         n_fail++;
         $display("FAIL burst_cmd_count: got %0d, required %0d", acc_log.size(), BL);
      end
      for (int i = 0; i < BL && i < acc_log.size(); i++) begin
         ea = 22'h3FFFF8 + A'(i);
         n_chk++;
         if (acc_log[i].addr !== ea || acc_log[i].we !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_addr[%0d]: got %h we=%b required %h we=0", i, acc_log[i].addr, acc_log[i].we, ea);
         end
      end
      tick();
   endtask

   task automatic test_outstanding_cap();
      int target;
      acc_log.delete();
      lat = 1;
      hold_rv = 1'b1;
      target = n_done + 1;
      vid_txn(22'h001000);
      repeat (20) tick();
      n_chk++;
      if (acc_log.size() != MO) begin
         n_fail++;
         $display("FAIL cap_accepts: got %0d, required %0d", acc_log.size(), MO);
      end
      n_chk++;
      if (ctrl_req !== 1'b0) begin
         n_fail++;
         $display("FAIL cap_req_low: got ctrl_req=%b, required 0", ctrl_req);
      end
      hold_rv = 1'b0;
      wait_vdone(target);
      n_chk++;
      if (acc_log.size() != BL) begin
         n_fail++;
         $display("FAIL cap_total: got %0d, required %0d", acc_log.size(), BL);
      end
      tick();
   endtask

   task automatic test_write();
      acc_log.delete();
      lat = 2;
      cpu_txn(1'b1, 22'h000155, 32'hCAFEF00D, 4'b0110, '0);
      n_chk++;
      if (acc_log.size() != 1 || acc_log[0].we !== 1'b1 || acc_log[0].be !== 4'b0110
          || acc_log[0].wdata !== 32'hCAFEF00D || acc_log[0].addr !== 22'h000155) begin
         n_fail++;
         $display("FAIL write_cmd: got %0d cmds (we/be/wdata/addr mismatch), required one write be=0110 data=CAFEF00D addr=000155",
                  acc_log.size());
      end
      tick();
   endtask

   task automatic test_contention();
      int target;
      order.delete();
      lat = 2;
      target = n_done + 2;
      fork
         cpu_txn(1'b0, 22'h0AAAAA, '0, 4'hF, {10'h2A5, 22'h0AAAAA});
         vid_txn(22'h100000);
         begin
            int base_vs;
            base_vs = n_vstart;
            for (int i = 0; i < 50 && n_vstart == base_vs; i++) tick();
            tick(); tick();
            vid_txn(22'h200000);
         end
      join
      wait_vdone(target);
      n_chk++;
      if (order.size() != 3 || order[0] != "V" || order[1] != "C" || order[2] != "V") begin
         n_fail++;
         $display("FAIL contention_order: got %0d events starting %s, required V C V",
                  order.size(), (order.size() > 0) ? string'(order[0]) : "none");
      end
      tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_cpu_read();
      test_video_burst();
      test_outstanding_cap();
      test_write();
      test_contention();
      repeat (5) tick();
      n_chk++;
      if (cpu_exp.size() != 0 || vid_exp.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d cpu / %0d video left, required 0 / 0",
                  cpu_exp.size(), vid_exp.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
